// File: rtl/chacha_pkg.sv
// Shared types and helpers for the ChaCha20 streaming datapath.
// Word i of a keystream block occupies bits [32i+31:32i].
package chacha_pkg;

  localparam int WORDS_PER_BLOCK = 16;
  localparam int WORD_W          = 32;
  localparam int BLK_W           = WORDS_PER_BLOCK * WORD_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_STREAM,
    ST_FLUSH
  } state_t;

  function automatic logic [WORD_W-1:0] ks_word(input logic [BLK_W-1:0] blk,
                                                input logic [3:0]       idx);
    return blk[{idx, 5'd0} +: WORD_W];
  endfunction

endpackage

// File: rtl/chacha_stream_decrypt.sv
// Streaming ChaCha20 decryptor: XORs a ciphertext word stream with keystream
// blocks fetched one at a time from an external block function.
//
// state     | meaning
// ST_IDLE   | no message; waiting for msg_start
// ST_REQ    | presenting ctr, waiting for block function idle to pulse ks_start
// ST_WAIT   | waiting for the keystream block
// ST_STREAM | decrypting up to 16 words from ks_buf
// ST_FLUSH  | counter space exhausted; discarding words until s_last
module chacha_stream_decrypt
  import chacha_pkg::*;
#(
  parameter int BLOCK_COUNT_WIDTH = 32,
  parameter int WIDTH             = 32,
  parameter int BLOCK_WIDTH       = 512
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         msg_start,
  input  logic [BLOCK_COUNT_WIDTH-1:0] init_count,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [WIDTH-1:0]             s_data,
  input  logic [WIDTH/8-1:0]           s_keep,
  input  logic                         s_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [WIDTH-1:0]             m_data,
  output logic [WIDTH/8-1:0]           m_keep,
  output logic                         m_last,
  output logic                         ks_start,
  output logic [BLOCK_COUNT_WIDTH-1:0] ks_block_count,
  input  logic                         ks_ready,
  input  logic                         ks_valid,
  input  logic [BLOCK_WIDTH-1:0]       ks_data,
  output logic                         busy,
  output logic                         err_ctr_ovf
);

  localparam int KEEP_W = WIDTH / 8;

  state_t                         state, state_nx;
  logic [BLOCK_COUNT_WIDTH-1:0]   ctr;
  logic [3:0]                     widx;
  logic [BLOCK_WIDTH-1:0]         ks_buf;
  logic [WIDTH-1:0]               byte_mask;
  logic [WIDTH-1:0]               plain;
  logic                           blk_end;
  logic                           ctr_max;
  logic                           stream_accept;

  assign blk_end        = (widx == 4'(WORDS_PER_BLOCK - 1));
  assign ctr_max        = &ctr;
  assign stream_accept  = (state == ST_STREAM) && s_valid && s_ready;
  assign ks_block_count = ctr;
  assign busy           = (state != ST_IDLE) || m_valid;

  always_comb begin
    byte_mask = '0;
    for (int i = 0; i < KEEP_W; i++) byte_mask[8*i +: 8] = {8{s_keep[i]}};
  end

  assign plain = (s_data ^ ks_word(ks_buf, widx)) & byte_mask;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    s_ready  = 1'b0;
    ks_start = 1'b0;
    case (state)
      ST_IDLE:   if (msg_start) state_nx = ST_REQ;
      ST_REQ: begin
        if (ks_ready) begin
          ks_start = 1'b1;
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT:   if (ks_valid) state_nx = ST_STREAM;
      ST_STREAM: begin
        s_ready = !m_valid || m_ready;
        if (s_valid && s_ready) begin
          if (s_last)       state_nx = ST_IDLE;
          else if (blk_end) state_nx = ctr_max ? ST_FLUSH : ST_REQ;
        end
      end
      ST_FLUSH: begin
        s_ready = 1'b1;
        if (s_valid && s_last) state_nx = ST_IDLE;
      end
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctr         <= '0;
      widx        <= '0;
      ks_buf      <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_keep      <= '0;
      m_last      <= 1'b0;
      err_ctr_ovf <= 1'b0;
    end else begin
      if (state == ST_IDLE && msg_start) begin
        ctr         <= init_count;
        err_ctr_ovf <= 1'b0;
      end
      if (state == ST_WAIT && ks_valid) begin
        ks_buf <= ks_data;
        widx   <= '0;
      end
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (stream_accept) begin
        m_valid <= 1'b1;
        m_data  <= plain;
        m_keep  <= s_keep;
        m_last  <= s_last;
        // the all-ones block is the last legal one; never wrap
        if (!s_last && blk_end) begin
          if (ctr_max) err_ctr_ovf <= 1'b1;
          else         ctr         <= ctr + BLOCK_COUNT_WIDTH'(1);
        end else if (!s_last) begin
          widx <= widx + 4'd1;
        end
      end
    end
  end

endmodule

// File: doc/chacha_stream_decrypt.md
# chacha_stream_decrypt

Streaming ChaCha20 decryptor: accepts ciphertext as a 32-bit word stream, requests one 512-bit keystream block at a time from a ChaCha block-function instance, and emits plaintext words (ciphertext XOR keystream) on a registered output stream. It is the receive-side counterpart to the single-block encrypt top. It handles arbitrary message lengths, increments the block counter per 64 bytes, and flags counter exhaustion. The parent holds key and nonce stable at the block function for the whole message.

## Interface
Parameters:
- BLOCK_COUNT_WIDTH, 32, ChaCha block counter width
- WIDTH, 32, stream word width
- BLOCK_WIDTH, 512, keystream block width; BLOCK_WIDTH/WIDTH = 16 words

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- msg_start  in  1  pulse: begin a message; sampled only in IDLE
- init_count  in  BLOCK_COUNT_WIDTH  first block counter, latched on msg_start
- s_valid / s_ready  in / out  1  ciphertext handshake
- s_data  in  WIDTH  ciphertext word
- s_keep  in  WIDTH/8  byte enables; only the s_last word may be partial, and it is LSB-contiguous
- s_last  in  1  final word of message
- m_valid / m_ready  out / in  1  plaintext handshake
- m_data  out  WIDTH  plaintext word; bytes with keep=0 forced to 0x00
- m_keep  out  WIDTH/8  copy of s_keep
- m_last  out  1  copy of s_last
- ks_start  out  1  one-cycle keystream request
- ks_block_count  out  BLOCK_COUNT_WIDTH  counter for the requested block
- ks_ready  in  1  block function idle
- ks_valid  in  1  keystream block valid (single-cycle pulse)
- ks_data  in  BLOCK_WIDTH  keystream; word i = ks_data[32i+31:32i]
- busy  out  1  state != IDLE or m_valid
- err_ctr_ovf  out  1  sticky: message exceeded counter space

## Operation
- States: IDLE, REQ, WAIT, STREAM, FLUSH.
- IDLE: msg_start -> latch init_count into ctr, clear err_ctr_ovf, go to REQ.
- REQ: drive ks_block_count = ctr. When ks_ready = 1, pulse ks_start for one cycle and go to WAIT.
- WAIT: on ks_valid, load ks_data into ks_buf, set widx = 0, go to STREAM.
- STREAM: s_ready = !m_valid || m_ready. On an accepted word:
  - register m_data = (s_data ^ ks_buf word widx) with the keep mask applied; m_keep and m_last copied from the input.
  - If s_last -> IDLE.
  - Else if widx = 15: if ctr = all-ones, set err_ctr_ovf and go to FLUSH; otherwise ctr += 1 and go to REQ.
  - Else widx += 1.
- FLUSH: s_ready = 1, accepted words are discarded with no output; s_last -> IDLE.
- A message ending exactly on word 15 with s_last returns to IDLE and issues no extra keystream request.
- Counter arithmetic is modulo 2^BLOCK_COUNT_WIDTH, but wrapping is never used; the all-ones block is the last legal block.
- s_ready = 0 in IDLE, REQ and WAIT.

## Timing
- Reset: state IDLE; s_ready, m_valid, m_data, m_keep, m_last, ks_start, ks_block_count, busy and err_ctr_ovf all 0.
- Reset mid-message aborts immediately; the partial message is lost and any pending m_valid is dropped.
- Latency:
  - accepted input word -> m_valid on the next cycle.
  - msg_start -> ks_start no earlier than the next cycle.
  - ks_valid -> s_ready high on the next cycle.
- Throughput: 1 word/cycle within a block. The bubble between blocks is 2 cycles plus the block-function latency.
- m_valid/m_data/m_keep/m_last hold stable while m_valid && !m_ready.
- Output drains after the return to IDLE. msg_start while m_valid is still pending is accepted, and the old word is preserved.
- msg_start outside IDLE is ignored.
- ks_valid outside WAIT is ignored.

## Structure
- Package chacha_pkg holds:
  - WORDS_PER_BLOCK = 16
  - the state enum type
  - a word-extract function
- The XOR/mask datapath and the FSM live in one module. No sub-module is required.
- The parent instantiates chacha_block_function beside this block.

## Test plan
- Single full block: init_count = 1, 16 words s_data = 0x00000000, model keystream word i = 0x11111111·(i+1) -> m_data = keystream words in order; m_last on word 15; exactly one ks_start with count 1.
- Multi-block: 20 words, last s_keep = 4'b0011 -> two requests (counts 5, 6); word 19 m_data upper two bytes = 0x00; m_keep = 4'b0011.
- Backpressure: m_ready toggling 1,0,0,1 -> no word lost or duplicated; m_data stable while stalled; s_ready = 0 during stall.
- Counter exhaustion: init_count = 0xFFFFFFFF, 18 words -> 16 outputs; err_ctr_ovf = 1; 2 words flushed; return to IDLE; no second ks_start.
- Reset mid-STREAM after word 7 -> next cycle all outputs 0; new msg_start restarts cleanly with the new init_count.
- msg_start pulsed during STREAM -> ignored; ctr unchanged.
